// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller: FSM state type, the
// per-width maximal-length feedback taps and the table of supported widths.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } bist_state_e;

    // Bit w is set when a vector width of w bits has a polynomial below.
    localparam logic [32:0] SUPPORTED_WIDTHS = 33'h1_0101_0100;

    // Fibonacci tap masks, bit i standing for polynomial term x^(i+1):
    // 8: x^8+x^6+x^5+x^4+1, 16: x^16+x^15+x^13+x^4+1,
    // 24: x^24+x^23+x^22+x^17+1, 32: x^32+x^22+x^2+x+1.
    function automatic logic [31:0] tap_mask(input int unsigned width);
        logic [31:0] mask;
        case (width)
            8:       mask = 32'h0000_00B8;
            16:      mask = 32'h0000_D008;
            24:      mask = 32'h00E1_0000;
            32:      mask = 32'h8020_0003;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bist_ctrl_param_if.sv
// Handshake and CUT bus between the system/CUT side (master) and the BIST
// controller (slave).
interface bist_ctrl_param_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             bist_start;
    logic [WIDTH-1:0] cut_response;
    logic [WIDTH-1:0] test_vector;
    logic             test_mode;
    logic             bist_end;
    logic             pass_nfail;

    modport master (
        output bist_start,
        output cut_response,
        input  test_vector,
        input  test_mode,
        input  bist_end,
        input  pass_nfail
    );

    modport slave (
        input  bist_start,
        input  cut_response,
        output test_vector,
        output test_mode,
        output bist_end,
        output pass_nfail
    );

endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci shift register used both as the pattern generator (xor_in tied
// to zero) and as the response compactor (xor_in fed by the CUT response).
module bist_lfsr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic [WIDTH-1:0] xor_in,
    output logic [WIDTH-1:0] state
);

    logic feedback;

    assign feedback = ^(state & TAPS);

    // Load has priority over a shift; a shift folds in the parallel input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
        end else if (load) begin
            state <= load_value;
        end else if (enable) begin
            state <= {state[WIDTH-2:0], feedback} ^ xor_in;
        end
    end

endmodule

// File: rtl/bist_ctrl_param.sv
// BIST session controller: LFSR stimulus, MISR compaction, golden compare.
// Optional build macro BIST_SIG_READBACK_EN exposes the MISR on 'signature'.
module bist_ctrl_param
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      N_PATTERNS  = 10,
    parameter int unsigned      CUT_LATENCY = 0,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter logic [WIDTH-1:0] GOLDEN      = '0
) (
    input  logic             clk,
    input  logic             reset,
    bist_ctrl_param_if.slave bus
`ifdef BIST_SIG_READBACK_EN
    ,
    output logic [WIDTH-1:0] signature
`endif
);

    // Step counter spans RUN and FLUSH, so it must hold N_PATTERNS+CUT_LATENCY.
    localparam int unsigned      CNT_W      = WIDTH + 4;
    localparam logic [31:0]      TAP_FULL   = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS       = TAP_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [CNT_W-1:0] N_CNT      = CNT_W'(N_PATTERNS);
    localparam logic [CNT_W-1:0] L_CNT      = CNT_W'(CUT_LATENCY);
    localparam logic [CNT_W-1:0] RUN_LAST   = N_CNT - CNT_W'(1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = N_CNT + L_CNT - CNT_W'(1);
    localparam bit               HAS_FLUSH  = (CUT_LATENCY != 0);

    if (!SUPPORTED_WIDTHS[WIDTH] || N_PATTERNS == 0 || CUT_LATENCY > 7) begin : g_bad_config
        $error("bist_ctrl_param: unsupported WIDTH, N_PATTERNS or CUT_LATENCY");
    end

    bist_state_e      state;
    bist_state_e      next_state;
    logic [CNT_W-1:0] step_cnt;
    logic             in_window;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] misr_state;

    logic             lfsr_load;
    logic             lfsr_en;
    logic             misr_clr;
    logic             misr_en;
    logic             cnt_clr;
    logic             cnt_en;
    logic             mode_set;
    logic             mode_clr;
    logic             end_set;
    logic             end_clr;
    logic             pass_clr;
    logic             pass_load;

    logic             test_mode_q;
    logic             bist_end_q;
    logic             pass_nfail_q;

    // The first CUT_LATENCY steps see responses to vectors not yet applied.
    if (HAS_FLUSH) begin : g_skip
        assign in_window = (step_cnt >= L_CNT);
    end else begin : g_noskip
        assign in_window = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; bist_start only matters in IDLE and DONE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.bist_start) next_state = ST_INIT;
            ST_INIT:    next_state = ST_RUN;
            ST_RUN:     if (step_cnt == RUN_LAST) next_state = HAS_FLUSH ? ST_FLUSH : ST_COMPARE;
            ST_FLUSH:   if (step_cnt == FLUSH_LAST) next_state = ST_COMPARE;
            ST_COMPARE: next_state = ST_DONE;
            ST_DONE:    if (!bus.bist_start) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Per-state strobes; the generator stops on the last RUN edge so the
    // final vector stays on the CUT inputs through FLUSH.
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        mode_set  = 1'b0;
        mode_clr  = 1'b0;
        end_set   = 1'b0;
        end_clr   = 1'b0;
        pass_clr  = 1'b0;
        pass_load = 1'b0;
        case (state)
            ST_INIT: begin
                lfsr_load = 1'b1;
                misr_clr  = 1'b1;
                cnt_clr   = 1'b1;
                mode_set  = 1'b1;
                pass_clr  = 1'b1;
            end
            ST_RUN: begin
                cnt_en  = 1'b1;
                lfsr_en = (step_cnt != RUN_LAST);
                misr_en = in_window;
            end
            ST_FLUSH: begin
                cnt_en  = 1'b1;
                misr_en = in_window;
            end
            ST_COMPARE: begin
                pass_load = 1'b1;
                mode_clr  = 1'b1;
                end_set   = 1'b1;
            end
            ST_DONE: begin
                end_clr = !bus.bist_start;
            end
            default: begin
            end
        endcase
    end

    // Step counter across RUN and FLUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (cnt_clr) begin
            step_cnt <= '0;
        end else if (cnt_en) begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    // Registered handshake outputs; pass_nfail survives until the next INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            test_mode_q  <= 1'b0;
            bist_end_q   <= 1'b0;
            pass_nfail_q <= 1'b0;
        end else begin
            if (mode_set) begin
                test_mode_q <= 1'b1;
            end else if (mode_clr) begin
                test_mode_q <= 1'b0;
            end
            if (end_set) begin
                bist_end_q <= 1'b1;
            end else if (end_clr) begin
                bist_end_q <= 1'b0;
            end
            if (pass_clr) begin
                pass_nfail_q <= 1'b0;
            end else if (pass_load) begin
                pass_nfail_q <= (misr_state == GOLDEN);
            end
        end
    end

    bist_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (lfsr_load),
        .load_value (SEED_EFF),
        .enable     (lfsr_en),
        .xor_in     ('0),
        .state      (lfsr_state)
    );

    bist_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_misr (
        .clk        (clk),
        .reset      (reset),
        .load       (misr_clr),
        .load_value ('0),
        .enable     (misr_en),
        .xor_in     (bus.cut_response),
        .state      (misr_state)
    );

    assign bus.test_vector = lfsr_state;
    assign bus.test_mode   = test_mode_q;
    assign bus.bist_end    = bist_end_q;
    assign bus.pass_nfail  = pass_nfail_q;

`ifdef BIST_SIG_READBACK_EN
    assign signature = misr_state;
`endif

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Bench for bist_ctrl_param: one instance with a direct loopback CUT and one
// with a 3-cycle CUT, both checked every cycle against a session model.
// Honours BIST_SIG_READBACK_EN when defined.
module tb_bist_ctrl_param;

    localparam int          N         = 10;
    localparam logic [7:0]  SEED      = 8'h01;
    localparam logic [7:0]  POLY      = 8'hB8;
    // In loopback the MISR reproduces the next generator state on each
    // capture, so every second captured vector cancels; ten captures end at 0.
    localparam logic [7:0]  GOLDEN    = 8'h00;
    localparam int          MODE_LOOP = 0;
    localparam int          MODE_FLIP = 1;
    localparam int          MODE_RAND = 2;
    localparam int          LAT [2]   = '{0, 3};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    int         mode;
    logic [7:0] rnd  [2];
    logic       flip [2];
    logic [7:0] dly  [3];

    int         n_checks = 0;
    int         n_fail   = 0;

    // Model state per instance: edges since the start edge (-1 when idle/done).
    int         mk    [2];
    logic       mdone [2];
    logic [7:0] mlfsr [2];
    logic [7:0] mmisr [2];
    logic [7:0] hist  [2][N];
    logic [7:0] etv   [2];
    logic       etm   [2];
    logic       eend  [2];
    logic       epass [2];

    logic [7:0] vec_lit [8];

`ifdef BIST_SIG_READBACK_EN
    logic [7:0] sig0;
    logic [7:0] sig3;
`endif

    always #5 clk = ~clk;

    bist_ctrl_param_if #(.WIDTH(8)) bus0 ();
    bist_ctrl_param_if #(.WIDTH(8)) bus3 ();

    assign bus0.bist_start   = start;
    assign bus3.bist_start   = start;
    assign bus0.cut_response = (mode == MODE_RAND) ? rnd[0] : (bus0.test_vector ^ {7'd0, flip[0]});
    assign bus3.cut_response = (mode == MODE_RAND) ? rnd[1] : (dly[2] ^ {7'd0, flip[1]});

    bist_ctrl_param #(
        .WIDTH(8), .N_PATTERNS(N), .CUT_LATENCY(0), .SEED(SEED), .GOLDEN(GOLDEN)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
`ifdef BIST_SIG_READBACK_EN
        ,
        .signature (sig0)
`endif
    );

    bist_ctrl_param #(
        .WIDTH(8), .N_PATTERNS(N), .CUT_LATENCY(3), .SEED(SEED), .GOLDEN(GOLDEN)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
`ifdef BIST_SIG_READBACK_EN
        ,
        .signature (sig3)
`endif
    );

    // Three-stage CUT pipeline in front of the latency-3 instance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) dly[i] <= 8'h00;
        end else begin
            dly[0] <= bus3.test_vector;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
        end
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & POLY)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Fresh junk responses every cycle; flip bit 0 of the response that
    // is captured for pattern 5 (capture j happens on edge L+2+j).
    always @(negedge clk) begin
        rnd[0]  = 8'($urandom);
        rnd[1]  = 8'($urandom);
        flip[0] = (mode == MODE_FLIP) && (mk[0] == LAT[0] + 6);
        flip[1] = (mode == MODE_FLIP) && (mk[1] == LAT[1] + 6);
    end

    // Session model: outputs as a function of edges elapsed since the start edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mk[i] = -1; mdone[i] = 1'b0; mlfsr[i] = 8'h00; mmisr[i] = 8'h00;
                etv[i] = 8'h00; etm[i] = 1'b0; eend[i] = 1'b0; epass[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mk[i] < 0) begin
                    if (mdone[i]) begin
                        if (!start) begin
                            mdone[i] = 1'b0;
                            eend[i]  = 1'b0;
                        end
                    end else if (start) begin
                        mk[i] = 0;
                    end
                end else begin
                    int e;
                    e = mk[i] + 1;
                    mk[i] = e;
                    if (e == 1) begin
                        mlfsr[i] = SEED; etv[i] = SEED; hist[i][0] = SEED;
                        mmisr[i] = 8'h00; etm[i] = 1'b1; epass[i] = 1'b0;
                    end else if (e <= N) begin
                        mlfsr[i] = lfsr_step(mlfsr[i]);
                        etv[i] = mlfsr[i];
                        hist[i][e-1] = mlfsr[i];
                    end
                    if (e >= 2 + LAT[i] && e <= N + LAT[i] + 1) begin
                        logic [7:0] r;
                        r = (mode == MODE_RAND) ? rnd[i] : (hist[i][e-2-LAT[i]] ^ {7'd0, flip[i]});
                        mmisr[i] = lfsr_step(mmisr[i]) ^ r;
                    end
                    if (e == N + LAT[i] + 2) begin
                        epass[i] = (mmisr[i] == GOLDEN);
                        etm[i] = 1'b0; eend[i] = 1'b1; mdone[i] = 1'b1; mk[i] = -1;
                    end
                end
            end
        end
    end

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        check_output("tv0",   32'(bus0.test_vector), 32'(etv[0]));
        check_output("tm0",   32'(bus0.test_mode),   32'(etm[0]));
        check_output("end0",  32'(bus0.bist_end),    32'(eend[0]));
        check_output("pass0", 32'(bus0.pass_nfail),  32'(epass[0]));
        check_output("tv3",   32'(bus3.test_vector), 32'(etv[1]));
        check_output("tm3",   32'(bus3.test_mode),   32'(etm[1]));
        check_output("end3",  32'(bus3.bist_end),    32'(eend[1]));
        check_output("pass3", 32'(bus3.pass_nfail),  32'(epass[1]));
`ifdef BIST_SIG_READBACK_EN
        check_output("sig0",  32'(sig0), 32'(mmisr[0]));
        check_output("sig3",  32'(sig3), 32'(mmisr[1]));
`endif
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, "_tv0"},   32'(bus0.test_vector), 32'h0);
        check_output({tag, "_tm0"},   32'(bus0.test_mode),   32'h0);
        check_output({tag, "_end0"},  32'(bus0.bist_end),    32'h0);
        check_output({tag, "_pass0"}, 32'(bus0.pass_nfail),  32'h0);
        check_output({tag, "_tv3"},   32'(bus3.test_vector), 32'h0);
        check_output({tag, "_tm3"},   32'(bus3.test_mode),   32'h0);
        check_output({tag, "_end3"},  32'(bus3.bist_end),    32'h0);
        check_output({tag, "_pass3"}, 32'(bus3.pass_nfail),  32'h0);
    endtask

    // One session from a start request; returns the edge index (E0 = start
    // edge) after which each instance raised bist_end, -1 if never seen.
    task automatic apply_stimulus(input int m, input bit hold, output int rise0, output int rise3);
        int e;
        mode  = m;
        rise0 = -1;
        rise3 = -1;
        @(posedge clk);
        #2 start = 1'b1;
        e = -1;
        while ((rise0 < 0 || rise3 < 0) && e < 40) begin
            @(posedge clk);
            e++;
            #1;
            if (e == 0 && !hold) start = 1'b0;
            if (rise0 < 0 && bus0.bist_end) rise0 = e;
            if (rise3 < 0 && bus3.bist_end) rise3 = e;
            if (m == MODE_LOOP && e >= 1 && e <= 8) begin
                check_output("vec_literal", 32'(bus0.test_vector), 32'(vec_lit[e-1]));
            end
        end
    endtask

    task automatic check_session(input string tag, input int rise0, input int rise3, input int exp_pass);
        check_output({tag, "_end_edge0"}, 32'(rise0), 32'd12);
        check_output({tag, "_end_edge3"}, 32'(rise3), 32'd15);
        if (exp_pass >= 0) begin
            check_output({tag, "_pass0"}, 32'(bus0.pass_nfail), 32'(exp_pass));
            check_output({tag, "_pass3"}, 32'(bus3.pass_nfail), 32'(exp_pass));
        end
    endtask

    initial begin
        int r0;
        int r3;
        vec_lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        start = 1'b0;
        mode  = MODE_LOOP;
        reset = 1'b0;
        #100;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check_output("idle_tm0", 32'(bus0.test_mode), 32'h0);
            check_output("idle_tm3", 32'(bus3.test_mode), 32'h0);
        end

        $display("[TB] loopback session");
        apply_stimulus(MODE_LOOP, 1'b0, r0, r3);
        check_session("loop", r0, r3, 1);

        $display("[TB] pattern 5 response corrupted");
        apply_stimulus(MODE_FLIP, 1'b0, r0, r3);
        check_session("flip", r0, r3, 0);

        $display("[TB] random responses");
        for (int s = 0; s < 3; s++) begin
            apply_stimulus(MODE_RAND, 1'b0, r0, r3);
            check_session("rand", r0, r3, -1);
        end

        $display("[TB] reset during RUN");
        mode = MODE_LOOP;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("run_pattern4", 32'(bus0.test_vector), 32'(vec_lit[4]));
        #2 reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(MODE_LOOP, 1'b0, r0, r3);
        check_session("restart", r0, r3, 1);

        $display("[TB] bist_start held through DONE");
        apply_stimulus(MODE_LOOP, 1'b1, r0, r3);
        check_session("hold", r0, r3, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check_output("hold_end0", 32'(bus0.bist_end), 32'h1);
            check_output("hold_end3", 32'(bus3.bist_end), 32'h1);
        end
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check_output("drop_end0",  32'(bus0.bist_end),   32'h0);
        check_output("drop_end3",  32'(bus3.bist_end),   32'h0);
        check_output("drop_pass0", 32'(bus0.pass_nfail), 32'h1);
        check_output("drop_pass3", 32'(bus3.pass_nfail), 32'h1);
`ifdef BIST_SIG_READBACK_EN
        check_output("sig0_golden", 32'(sig0), 32'(GOLDEN));
        check_output("sig3_golden", 32'(sig3), 32'(GOLDEN));
`endif
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
